// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the RV32I fetch/load-store ports, the arbiter and the memory.
// The arbiter connects through the slave modport; the environment uses master.
interface rv32i_mem_arbiter_if;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        o_inst_ack;
    logic [31:0] o_inst_rdata;
    logic        o_inst_err;
    logic        i_data_req;
    logic        i_data_wr;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wdata;
    logic [3:0]  i_data_wstrb;
    logic        o_data_ack;
    logic [31:0] o_data_rdata;
    logic        o_data_err;
    logic        o_mem_req;
    logic        o_mem_wr;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_inst_req, i_inst_addr,
        output o_inst_ack, o_inst_rdata, o_inst_err,
        input  i_data_req, i_data_wr, i_data_addr, i_data_wdata, i_data_wstrb,
        output o_data_ack, o_data_rdata, o_data_err,
        output o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        input  i_mem_ack, i_mem_rdata
    );

    modport master (
        output i_inst_req, i_inst_addr,
        input  o_inst_ack, o_inst_rdata, o_inst_err,
        output i_data_req, i_data_wr, i_data_addr, i_data_wdata, i_data_wstrb,
        input  o_data_ack, o_data_rdata, o_data_err,
        input  o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata, o_mem_wstrb,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single-outstanding memory port,
// alternating priority, with a wait-cycle timeout that returns a bus error.
module rv32i_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rv32i_mem_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

    state_t            state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_inst_q, last_inst_d;

    logic              grant_i, grant_d, release_bus, timeout, done;
    logic              inst_ack, inst_err, data_ack, data_err;
    logic [DATA_W-1:0] inst_rdata, data_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            last_inst_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            last_inst_q <= last_inst_d;
        end
    end

    // A real ack always wins over a coinciding timeout.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        last_inst_d = last_inst_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        release_bus = 1'b0;
        inst_ack    = 1'b0;
        inst_err    = 1'b0;
        inst_rdata  = '0;
        data_ack    = 1'b0;
        data_err    = 1'b0;
        data_rdata  = '0;
        timeout     = !bus.i_mem_ack && (cnt_q == CNT_W'(TIMEOUT));
        done        = bus.i_mem_ack || timeout;

        unique case (state_q)
            IDLE: begin
                if (bus.i_data_req && (!bus.i_inst_req || last_inst_q)) grant_d = 1'b1;
                else if (bus.i_inst_req)                                grant_i = 1'b1;
            end
            GRANT_I: begin
                if (done) begin
                    inst_ack   = 1'b1;
                    inst_err   = timeout;
                    inst_rdata = bus.i_mem_ack ? bus.i_mem_rdata : '0;
                    if (bus.i_data_req) grant_d     = 1'b1;
                    else                release_bus = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GRANT_D: begin
                if (done) begin
                    data_ack   = 1'b1;
                    data_err   = timeout;
                    data_rdata = bus.i_mem_ack ? bus.i_mem_rdata : '0;
                    if (bus.i_inst_req) grant_i     = 1'b1;
                    else                release_bus = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Payload is captured on the edge that enters a grant.
        if (grant_i) begin
            state_d     = GRANT_I;
            cmd_d       = '{req: 1'b1, wr: 1'b0, addr: bus.i_inst_addr,
                            wdata: DATA_W'(0), wstrb: STRB_W'(0)};
            cnt_d       = '0;
            last_inst_d = 1'b1;
        end else if (grant_d) begin
            state_d     = GRANT_D;
            cmd_d       = '{req: 1'b1, wr: bus.i_data_wr, addr: bus.i_data_addr,
                            wdata: bus.i_data_wdata, wstrb: bus.i_data_wstrb};
            cnt_d       = '0;
            last_inst_d = 1'b0;
        end else if (release_bus) begin
            state_d = IDLE;
            cmd_d   = '0;
            cnt_d   = '0;
        end
    end

    assign bus.o_mem_req    = cmd_q.req;
    assign bus.o_mem_wr     = cmd_q.wr;
    assign bus.o_mem_addr   = cmd_q.addr;
    assign bus.o_mem_wdata  = cmd_q.wdata;
    assign bus.o_mem_wstrb  = cmd_q.wstrb;
    assign bus.o_inst_ack   = inst_ack;
    assign bus.o_inst_err   = inst_err;
    assign bus.o_inst_rdata = inst_rdata;
    assign bus.o_data_ack   = data_ack;
    assign bus.o_data_err   = data_err;
    assign bus.o_data_rdata = data_rdata;
endmodule
